// File: rtl/mlu_serial.sv
// mlu_serial: slice-serial MLU between register file and writeback.
//   ADD/SUB run one SLICE_W slice per clock with a registered carry.
//   AND/OR/XOR/NOT/NOP finish in one cycle (LOGIC_ONE_CYCLE=1) or run serially.
//   A DONE-state hold buffer keeps OUT and its flags stable under backpressure.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   IN_VALID/IN_READY     operand handshake (IN_READY high only in IDLE)
//   A, B, OP, C_IN        operands, common::MLU_* opcode, carry into slice 0
//   OUT_VALID/OUT_READY   result handshake (OUT_VALID high only in DONE)
//   OUT, C_OUT, ZERO,     result, final carry, zero/negative/signed-overflow flags
//   NEG, OVF

package common;
    typedef enum logic [2:0] {
        MLU_ADD  = 3'd0,
        MLU_SUB  = 3'd1,
        MLU_AND  = 3'd2,
        MLU_OR   = 3'd3,
        MLU_XOR  = 3'd4,
        MLU_NOT  = 3'd5,
        MLU_NOP0 = 3'd6,
        MLU_NOP1 = 3'd7
    } mlu_op_e;
endpackage

module mlu_serial #(
    parameter int WIDTH           = 16,
    parameter int SLICE_W         = 4,
    parameter int LOGIC_ONE_CYCLE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             C_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             C_OUT,
    output logic             ZERO,
    output logic             NEG,
    output logic             OVF
);
    import common::*;

    localparam int NSLICES = WIDTH / SLICE_W;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    if ((SLICE_W < 1) || (WIDTH % SLICE_W != 0)) begin : g_bad_width
        $error("mlu_serial: WIDTH must be a positive multiple of SLICE_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             state_q;
    logic               in_ready_q, out_valid_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    mlu_op_e            op_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               c_out_q, zero_q, neg_q, ovf_q;

    logic               is_arith, fast_logic, last_d;
    logic [WIDTH-1:0]   b_eff, logic_word, res_d;
    logic [SLICE_W-1:0] a_s, b_s;
    logic [SLICE_W:0]   sum;
    logic               carry_d, c_out_d, zero_d, neg_d, ovf_d;

    always_comb begin
        is_arith   = (op_q == MLU_ADD) || (op_q == MLU_SUB);
        fast_logic = (LOGIC_ONE_CYCLE != 0) && !is_arith;
        b_eff      = (op_q == MLU_SUB) ? ~b_q : b_q;

        a_s = a_q[idx_q*SLICE_W +: SLICE_W];
        b_s = b_eff[idx_q*SLICE_W +: SLICE_W];
        sum = {1'b0, a_s} + {1'b0, b_s} + {{SLICE_W{1'b0}}, carry_q};

        logic_word = '0;
        case (op_q)
            MLU_AND: logic_word = a_q & b_q;
            MLU_OR:  logic_word = a_q | b_q;
            MLU_XOR: logic_word = a_q ^ b_q;
            MLU_NOT: logic_word = ~a_q;
            default: logic_word = '0;   // NOP0/NOP1 and arithmetic
        endcase

        res_d = res_q;
        if (fast_logic) begin
            res_d = logic_word;
        end else if (is_arith) begin
            res_d[idx_q*SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
        end else begin
            res_d[idx_q*SLICE_W +: SLICE_W] = logic_word[idx_q*SLICE_W +: SLICE_W];
        end

        // Serial logic ops keep the carry at zero so C_OUT reads 0.
        carry_d = is_arith ? sum[SLICE_W] : 1'b0;
        last_d  = fast_logic || (idx_q == IDX_W'(NSLICES - 1));

        // Flags describe the word as it will look after this edge.
        c_out_d = carry_d;
        zero_d  = (res_d == '0);
        neg_d   = res_d[WIDTH-1];
        ovf_d   = is_arith && (a_q[WIDTH-1] == b_eff[WIDTH-1])
                           && (res_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= MLU_ADD;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            c_out_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (IN_VALID) begin
                        a_q        <= A;
                        b_q        <= B;
                        op_q       <= mlu_op_e'(OP);
                        carry_q    <= C_IN;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    if (last_d) begin
                        c_out_q     <= c_out_d;
                        zero_q      <= zero_d;
                        neg_q       <= neg_d;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT       = res_q;
    assign C_OUT     = c_out_q;
    assign ZERO      = zero_q;
    assign NEG       = neg_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_mlu_serial.sv
// tb_mlu_serial: drives a one-cycle-logic instance (u_one) and a fully serial
// instance (u_ser) from the same inputs and checks both against constant
// vectors, hand-built corner sequences and an arithmetic reference model.
module tb_mlu_serial;
    import common::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic [2:0]  OP = '0;
    logic        C_IN = 1'b0;
    logic        OUT_READY = 1'b1;

    logic        o_rdy, o_vld, o_c, o_z, o_n, o_v;
    logic [15:0] o_out;
    logic        s_rdy, s_vld, s_c, s_z, s_n, s_v;
    logic [15:0] s_out;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mlu_serial #(.WIDTH(16), .SLICE_W(4), .LOGIC_ONE_CYCLE(1)) u_one (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(o_rdy),
        .A(A), .B(B), .OP(OP), .C_IN(C_IN),
        .OUT_VALID(o_vld), .OUT_READY(OUT_READY), .OUT(o_out),
        .C_OUT(o_c), .ZERO(o_z), .NEG(o_n), .OVF(o_v)
    );

    mlu_serial #(.WIDTH(16), .SLICE_W(4), .LOGIC_ONE_CYCLE(0)) u_ser (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(s_rdy),
        .A(A), .B(B), .OP(OP), .C_IN(C_IN),
        .OUT_VALID(s_vld), .OUT_READY(OUT_READY), .OUT(s_out),
        .C_OUT(s_c), .ZERO(s_z), .NEG(s_n), .OVF(s_v)
    );

    // Packed result: {OUT, C_OUT, ZERO, NEG, OVF}
    function automatic logic [19:0] p1();
        return {o_out, o_c, o_z, o_n, o_v};
    endfunction
    function automatic logic [19:0] p2();
        return {s_out, s_c, s_z, s_n, s_v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: whole-word integer arithmetic, signed range test for overflow.
    function automatic logic [19:0] model(logic [2:0] op, logic [15:0] a, logic [15:0] b, logic cin);
        int u, s;
        logic [15:0] o;
        logic c, v;
        o = '0; c = 1'b0; v = 1'b0;
        if (op == MLU_ADD || op == MLU_SUB) begin
            if (op == MLU_ADD) begin
                u = int'(a) + int'(b) + int'(cin);
                s = int'($signed(a)) + int'($signed(b)) + int'(cin);
            end else begin
                u = int'(a) + (65535 - int'(b)) + int'(cin);
                s = int'($signed(a)) - int'($signed(b)) - 1 + int'(cin);
            end
            o = u[15:0];
            c = (u > 65535);
            v = (s < -32768) || (s > 32767);
        end else if (op == MLU_AND) o = a & b;
        else if (op == MLU_OR)  o = a | b;
        else if (op == MLU_XOR) o = a ^ b;
        else if (op == MLU_NOT) o = ~a;
        return {o, c, (o == 16'h0), o[15], v};
    endfunction

    // Issue one op to both instances (both must be idle) and collect each
    // result at its first OUT_VALID sample, checking it holds while stalled.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input bit bp,
                          output logic [19:0] r1, output int l1,
                          output logic [19:0] r2, output int l2);
        bit s1, s2, d1, d2;
        logic [19:0] cur;
        s1 = 0; s2 = 0; d1 = 0; d2 = 0;
        r1 = '0; r2 = '0; l1 = -1; l2 = -1;
        check("accept_ready", {o_rdy, s_rdy}, 2'b11);
        A = a; B = b; OP = op; C_IN = cin; IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = 16'($urandom); B = 16'($urandom); OP = 3'($urandom); C_IN = 1'($urandom);
        for (int e = 1; e <= 60 && !(d1 && d2); e++) begin
            @(posedge CLK); #1;
            if (o_vld) begin
                cur = p1();
                if (!s1) begin s1 = 1; r1 = cur; l1 = e; end
                else check("hold_one", cur, r1);
            end else if (s1) d1 = 1;
            if (s_vld) begin
                cur = p2();
                if (!s2) begin s2 = 1; r2 = cur; l2 = e; end
                else check("hold_ser", cur, r2);
            end else if (s2) d2 = 1;
            OUT_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("op_complete", {d1, d2}, 2'b11);
        OUT_READY = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] out;
        logic        cout, zero, neg, ovf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [19:0] r1, r2, exp, snap1, snap2;
        int l1, l2;
        bit lg;

        tbl[0]  = '{MLU_ADD,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{MLU_ADD,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{MLU_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{MLU_SUB,  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{MLU_SUB,  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{MLU_XOR,  16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{MLU_NOT,  16'h0F0F, 16'h1234, 1'b1, 16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{MLU_AND,  16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{MLU_OR,   16'h1200, 16'h0034, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{MLU_NOP0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{MLU_NOP1, 16'h8001, 16'h7FFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{MLU_SUB,  16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{MLU_ADD,  16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_one", {o_rdy, o_vld, p1()}, {1'b1, 1'b0, 20'h0});
        check("rst_ser", {s_rdy, s_vld, p2()}, {1'b1, 1'b0, 20'h0});
        @(posedge CLK); #1;
        check("idle_ready", {o_rdy, s_rdy, o_vld, s_vld}, 4'b1100);

        // Directed vectors, no backpressure
        foreach (tbl[i]) begin
            exp = {tbl[i].out, tbl[i].cout, tbl[i].zero, tbl[i].neg, tbl[i].ovf};
            lg  = !(tbl[i].op == MLU_ADD || tbl[i].op == MLU_SUB);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, r1, l1, r2, l2);
            check($sformatf("vec%0d_one", i), r1, exp);
            check($sformatf("vec%0d_ser", i), r2, exp);
            check($sformatf("vec%0d_lat_one", i), l1, lg ? 1 : 4);
            check($sformatf("vec%0d_lat_ser", i), l2, 4);
        end

        // Backpressure: result held for 5 cycles, new requests ignored
        A = 16'h1234; B = 16'h4321; OP = MLU_ADD; C_IN = 1'b0;
        IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        for (int e = 0; e < 10 && !(o_vld && s_vld); e++) begin
            @(posedge CLK); #1;
        end
        check("bp_valid", {o_vld, s_vld}, 2'b11);
        snap1 = p1(); snap2 = p2();
        check("bp_result", snap1, model(MLU_ADD, 16'h1234, 16'h4321, 1'b0));
        for (int k = 0; k < 5; k++) begin
            IN_VALID = 1'b1; A = 16'($urandom); B = 16'($urandom); OP = MLU_SUB;
            @(posedge CLK); #1;
            check("bp_hold_one", p1(), snap1);
            check("bp_hold_ser", p2(), snap2);
            check("bp_state", {o_rdy, s_rdy, o_vld, s_vld}, 4'b0011);
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        check("bp_release", {o_rdy, s_rdy, o_vld, s_vld}, 4'b1100);

        // Reset two edges into an ADD aborts it
        A = 16'h1111; B = 16'h2222; OP = MLU_ADD; C_IN = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_one", {o_rdy, o_vld, p1()}, {1'b1, 1'b0, 20'h0});
        check("abort_ser", {s_rdy, s_vld, p2()}, {1'b1, 1'b0, 20'h0});
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            check("abort_no_valid", {o_vld, s_vld}, 2'b00);
        end
        run_op(MLU_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0, r1, l1, r2, l2);
        check("post_abort_one", r1, {16'h3333, 4'b0000});
        check("post_abort_ser", r2, {16'h3333, 4'b0000});

        // Random ops with toggling backpressure
        for (int n = 0; n < 2500; n++) begin
            logic [2:0]  op;
            logic [15:0] a, b;
            logic        cin;
            op  = 3'($urandom_range(0, 7));
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            if (n % 16 == 0) a = 16'h7FFF + 16'($urandom_range(0, 2));
            exp = model(op, a, b, cin);
            run_op(op, a, b, cin, 1'b1, r1, l1, r2, l2);
            check($sformatf("rnd%0d_one op=%0d a=%h b=%h c=%0d", n, op, a, b, cin), r1, exp);
            check($sformatf("rnd%0d_ser op=%0d a=%h b=%h c=%0d", n, op, a, b, cin), r2, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
